bigsum_leading_digits: RTL and testbench
========================================

Name: bigsum_leading_digits

Overview:
- Streaming successor to the fixed-table big-number summer.
- Accepts any count of decimal numbers, up to MAX_DIGITS digits each, as a valid/ready digit stream, most significant digit (MSD) first.
- Accumulates the exact sum, then outputs its leading LEAD_DIGITS decimal digits as a binary value.
- Sits as a Project-Euler compute core fed by a testbench or ROM streamer; done/error outputs match the rest of the codebase.

Parameters:
- MAX_DIGITS, 50, max digits per input number; a longer number is an error.
- SUM_W, 173, accumulator/sum width in bits; must hold max_count*10^MAX_DIGITS.
- LEAD_DIGITS, 10, number of leading decimal digits reported.
- RES_W, 40, result width; must satisfy 2^RES_W > 10^LEAD_DIGITS.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new run from IDLE or DONE.
- digit_in  in  4  BCD digit, 0..9 (8-bit ASCII when ASCII_IN_EN is defined).
- digit_valid  in  1  digit_in is valid.
- digit_last  in  1  qualifies the current digit as the last digit (LSD) of the number.
- num_last  in  1  qualifies a digit_last beat as the end of the final number.
- digit_ready  out  1  block accepts a digit this cycle.
- result  out  RES_W  leading LEAD_DIGITS digits of the sum, binary.
- count  out  16  numbers summed in this run.
- done  out  1  run complete; result/count/error are stable.
- error  out  1  run aborted by a malformed stream.

Behaviour:
- Reset: state=IDLE; result=0, count=0, done=0, error=0, digit_ready=0, accumulators cleared. Reset takes priority over every other input, including mid-run; any partial sum is discarded.
- States: IDLE, LOAD, ADD, REDUCE, DONE.
- IDLE: digit_ready=0. start -> LOAD. In the transition cycle: number=0, sum=0, digit counter=0, count=0, done=0, error=0.
- LOAD: digit_ready=1.
  - A beat is accepted when digit_valid && digit_ready.
  - On each beat: number <= number*10 + digit; digit counter +1.
  - digit_last on a beat -> ADD, after folding that digit in.
  - Gaps (digit_valid=0) simply wait; there is no timeout.
- ADD (1 cycle, digit_ready=0): sum <= sum + number; count+1; number=0; digit counter=0. Next state is REDUCE if num_last was set on the last beat, else LOAD. num_last without digit_last is ignored.
- REDUCE: one step per cycle.
  - If sum < 10^LEAD_DIGITS: result <= sum[RES_W-1:0]; -> DONE.
  - Else sum <= sum/10.
  - Latency is (decimal length of sum - LEAD_DIGITS) cycles, plus 1.
- DONE: done=1 and held. start -> LOAD via IDLE-style clear, in a single cycle. start in LOAD/ADD/REDUCE is ignored.
- Errors (enter DONE with error=1, done=1, result=0; the offending beat is still accepted):
  - A digit value > 9.
  - A beat that would make the digit counter exceed MAX_DIGITS.
- Boundaries:
  - Empty number (digit_last on the first beat with digit 0) is legal and adds 0.
  - A sum with fewer digits than LEAD_DIGITS is reported whole; an all-zero sum gives result=0.
  - count saturates at 16'hFFFF. The sum is not checked for overflow; SUM_W sizing is the integrator's duty.
- Arithmetic is unsigned throughout. number*10 is formed as (number<<3)+(number<<1) at SUM_W width.

Optional Feature:
- Macro: BIGSUM_ASCII_IN_EN.
- Defined: digit_in is 8 bits of ASCII. The accepted digit is digit_in - "0"; any byte outside "0".."9" is an error.
- Undefined: digit_in is 4-bit BCD with the >9 check above.

Decomposition:
- Package bigsum_pkg:
  - state enum (IDLE, LOAD, ADD, REDUCE, DONE);
  - ASCII_ZERO constant;
  - a function computing 10^LEAD_DIGITS at SUM_W width.
- Sub-module div10_step: combinational SUM_W-bit divide-by-10 (quotient only), used by REDUCE. It is isolated for synthesis timing review.

Test Plan:
- Defaults, full 100x50-digit Euler set streamed MSD-first with no gaps -> done=1, error=0, count=100, result=5537376230.
- LEAD_DIGITS=2; numbers "99", "1" with random digit_valid gaps -> result=10, count=2.
- Single number "0" with digit_last&num_last -> result=0, done=1 after ADD+REDUCE (2 cycles after the beat).
- Digit value 12 on the 3rd beat -> error=1, done=1, result=0; subsequent start runs cleanly.
- MAX_DIGITS=4; number "12345" -> error raised on the 5th beat; digit_ready low afterwards.
- rst pulsed mid-LOAD at number 40 -> all outputs 0, IDLE. A fresh start with the full set still gives 5537376230.

Source files
------------

// File: rtl/bigsum_pkg.sv
// bigsum_pkg: state encoding and shared constants for bigsum_leading_digits.
package bigsum_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ADD, REDUCE, DONE} state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int POW_W = 512;

    // Wide enough for any practical LEAD_DIGITS; callers truncate to SUM_W.
    function automatic logic [POW_W-1:0] pow10(input int n);
        logic [POW_W-1:0] p;
        p = POW_W'(1);
        for (int i = 0; i < n; i++) p = (p << 3) + (p << 1);
        return p;
    endfunction

endpackage

// File: rtl/div10_step.sv
// div10_step: combinational W-bit unsigned divide-by-10 (quotient only), restoring long division.
module div10_step #(
    parameter int W = 173
) (
    input  logic [W-1:0] dividend,
    output logic [W-1:0] quotient
);

    logic [4:0] rem;

    always_comb begin
        quotient = '0;
        rem = '0;
        for (int i = W - 1; i >= 0; i--) begin
            rem = {rem[3:0], dividend[i]};
            quotient[i] = rem >= 5'd10;
            if (quotient[i]) rem = rem - 5'd10;
        end
    end

endmodule

// File: rtl/bigsum_leading_digits.sv
// bigsum_leading_digits: streams decimal numbers MSD-first, sums them, reports the leading LEAD_DIGITS digits.
// Define BIGSUM_ASCII_IN_EN to take 8-bit ASCII digits instead of 4-bit BCD.
module bigsum_leading_digits
    import bigsum_pkg::*;
#(
    parameter int MAX_DIGITS  = 50,
    parameter int SUM_W       = 173,
    parameter int LEAD_DIGITS = 10,
    parameter int RES_W       = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef BIGSUM_ASCII_IN_EN
    input  logic [7:0]       digit_in,
`else
    input  logic [3:0]       digit_in,
`endif
    input  logic             digit_valid,
    input  logic             digit_last,
    input  logic             num_last,
    output logic             digit_ready,
    output logic [RES_W-1:0] result,
    output logic [15:0]      count,
    output logic             done,
    output logic             error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(pow10(LEAD_DIGITS));

    state_t           state;
    logic [SUM_W-1:0] number, sum, sum_div10, number_next;
    logic [CNT_W-1:0] digit_cnt;
    logic             last_num, beat, too_long, bad_digit;
    logic [3:0]       digit;

`ifdef BIGSUM_ASCII_IN_EN
    logic [7:0] ascii_off;
    // Bytes below "0" wrap to large values, so one compare rejects both sides.
    assign ascii_off = digit_in - ASCII_ZERO;
    assign digit     = ascii_off[3:0];
    assign bad_digit = ascii_off > 8'd9;
`else
    assign digit     = digit_in;
    assign bad_digit = digit_in > 4'd9;
`endif

    assign beat        = digit_valid && digit_ready;
    assign too_long    = digit_cnt == CNT_W'(MAX_DIGITS);
    assign number_next = (number << 3) + (number << 1) + SUM_W'(digit);

    div10_step #(.W(SUM_W)) u_div10 (
        .dividend(sum),
        .quotient(sum_div10)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            number      <= '0;
            sum         <= '0;
            digit_cnt   <= '0;
            last_num    <= 1'b0;
            result      <= '0;
            count       <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            digit_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) begin
                    state       <= LOAD;
                    number      <= '0;
                    sum         <= '0;
                    digit_cnt   <= '0;
                    count       <= '0;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    digit_ready <= 1'b1;
                end
                LOAD: if (beat) begin
                    if (bad_digit || too_long) begin
                        state       <= DONE;
                        error       <= 1'b1;
                        done        <= 1'b1;
                        result      <= '0;
                        digit_ready <= 1'b0;
                    end else begin
                        number    <= number_next;
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        last_num  <= num_last;
                        if (digit_last) begin
                            state       <= ADD;
                            digit_ready <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    sum         <= sum + number;
                    count       <= (count == 16'hFFFF) ? count : count + 16'd1;
                    number      <= '0;
                    digit_cnt   <= '0;
                    state       <= last_num ? REDUCE : LOAD;
                    digit_ready <= !last_num;
                end
                REDUCE: begin
                    if (sum < LIMIT) begin
                        result <= sum[RES_W-1:0];
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        sum <= sum_div10;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bigsum_leading_digits.sv
// tb_bigsum_leading_digits: scoreboard bench; a default-sized DUT runs the Euler set, a tiny DUT covers short-width corners.
module tb_bigsum_leading_digits;

    typedef struct packed {
        logic [39:0] res;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, dvalid, dlast, nlast, sel, rdy;
    logic [3:0]  din;
    logic        rdy_a, done_a, err_a, rdy_b, done_b, err_b;
    logic [39:0] res_a;
    logic [7:0]  res_b;
    logic [15:0] cnt_a, cnt_b;
    logic        pd_a = 1'b0, pd_b = 1'b0;
    exp_t        q_a[$], q_b[$];
    exp_t        e_a, e_b;
    int          n_vec = 0, n_err = 0;

    string euler [100] = '{
        "37107287533902102798797998220837590246510135740250", "46376937677490009712648124896970078050417018260538",
        "74324986199524741059474233309513058123726617309629", "91942213363574161572522430563301811072406154908250",
        "23067588207539346171171980310421047513778063246676", "89261670696623633820136378418383684178734361726757",
        "28112879812849979408065481931592621691275889832738", "44274228917432520321923589422876796487670272189318",
        "47451445736001306439091167216856844588711603153276", "70386486105843025439939619828917593665686757934951",
        "62176457141856560629502157223196586755079324193331", "64906352462741904929101432445813822663347944758178",
        "92575867718337217661963751590579239728245598838407", "58203565325359399008402633568948830189458628227828",
        "80181199384826282014278194139940567587151170094390", "35398664372827112653829987240784473053190104293586",
        "86515506006295864861532075273371959191420517255829", "71693888707715466499115593487603532921714970056938",
        "54370070576826684624621495650076471787294438377604", "53282654108756828443191190634694037855217779295145",
        "36123272525000296071075082563815656710885258350721", "45876576172410976447339110607218265236877223636045",
        "17423706905851860660448207621209813287860733969412", "81142660418086830619328460811191061556940512689692",
        "51934325451728388641918047049293215058642563049483", "62467221648435076201727918039944693004732956340691",
        "15732444386908125794514089057706229429197107928209", "55037687525678773091862540744969844508330393682126",
        "18336384825330154686196124348767681297534375946515", "80386287592878490201521685554828717201219257766954",
        "78182833757993103614740356856449095527097864797581", "16726320100436897842553539920931837441497806860984",
        "48403098129077791799088218795327364475675590848030", "87086987551392711854517078544161852424320693150332",
        "59959406895756536782107074926966537676326235447210", "69793950679652694742597709739166693763042633987085",
        "41052684708299085211399427365734116182760315001271", "65378607361501080857009149939512557028198746004375",
        "35829035317434717326932123578154982629742552737307", "94953759765105305946966067683156574377167401875275",
        "88902802571733229619176668713819931811048770190271", "25267680276078003013678680992525463401061632866526",
        "36270218540497705585629946580636237993140746255962", "24074486908231174977792365466257246923322810917141",
        "91430288197103288597806669760892938638285025333403", "34413065578016127815921815005561868836468420090470",
        "23053081172816430487623791969842487255036638784583", "11487696932154902810424020138335124462181441773470",
        "63783299490636259666498587618221225225512486764533", "67720186971698544312419572409913959008952310058822",
        "95548255300263520781532296796249481641953868218774", "76085327132285723110424803456124867697064507995236",
        "37774242535411291684276865538926205024910326572967", "23701913275725675285653248258265463092207058596522",
        "29798860272258331913126375147341994889534765745501", "18495701454879288984856827726077713721403798879715",
        "38298203783031473527721580348144513491373226651381", "34829543829199918180278916522431027392251122869539",
        "40957953066405232632538044100059654939159879593635", "29746152185502371307642255121183693803580388584903",
        "41698116222072977186158236678424689157993532961922", "62467957194401269043877107275048102390895523597457",
        "23189706772547915061505504953922979530901129967519", "86188088225875314529584099251203829009407770775672",
        "11306739708304724483816533873502340845647058077308", "82959174767140363198008187129011875491310547126581",
        "97623331044818386269515456334926366572897563400500", "42846280183517070527831839425882145521227251250327",
        "55121603546981200581762165212827652751691296897789", "32238195734329339946437501907836945765883352399886",
        "75506164965184775180738168837861091527357929701337", "62177842752192623401942399639168044983993173312731",
        "32924185707147349566916674687634660915035914677504", "99518671430235219628894890102423325116913619626622",
        "73267460800591547471830798392868535206946944540724", "76841822524674417161514036427982273348055556214818",
        "97142617910342598647204516893989422179826088076852", "87783646182799346313767754307809363333018982642090",
        "10848802521674670883215120185883543223812876952786", "71329612474782464538636993009049310363619763878039",
        "62184073572399794223406235393808339651327408011116", "66627891981488087797941876876144230030984490851411",
        "60661826293682836764744779239180335110989069790714", "85786944089552990653640447425576083659976645795096",
        "66024396409905389607120198219976047599490197230297", "64913982680032973156037120041377903785566085089252",
        "16730939319872750275468906903707539413042652315011", "94809377245048795150954100921645863754710598436791",
        "78639167021187492431995700641917969777599028300699", "15368713711936614952811305876380278410754449733078",
        "40789923115535562561142322423255033685442488917353", "44889911501440648020369068063960672322193204149535",
        "41503128880339536053299340368006977710650566631954", "81234880673210146739058568557934581403627822703280",
        "82616570773948327592232845941706525094512325230608", "22918802058777319719839450180888072429661980811197",
        "77158542502016545090413245809786882778948721859617", "72107838435069186155435662884062257473692284509516",
        "20849603980134001723930671666823555245252804609722", "53503534226472524250874054075591789781264330331690"
    };

    always #5 clk = ~clk;

    assign rdy = sel ? rdy_b : rdy_a;

    bigsum_leading_digits u_dut (
        .clk(clk), .rst(rst), .start(start && !sel), .digit_in(din),
        .digit_valid(dvalid && !sel), .digit_last(dlast), .num_last(nlast),
        .digit_ready(rdy_a), .result(res_a), .count(cnt_a), .done(done_a), .error(err_a)
    );

    bigsum_leading_digits #(.MAX_DIGITS(4), .SUM_W(32), .LEAD_DIGITS(2), .RES_W(8)) u_small (
        .clk(clk), .rst(rst), .start(start && sel), .digit_in(din),
        .digit_valid(dvalid && sel), .digit_last(dlast), .num_last(nlast),
        .digit_ready(rdy_b), .result(res_b), .count(cnt_b), .done(done_b), .error(err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent wide-integer reference for the leading digits of the Euler sum.
    function automatic logic [39:0] euler_lead(input int n);
        logic [199:0] s, v;
        string        t;
        s = '0;
        for (int k = 0; k < n; k++) begin
            t = euler[k];
            v = '0;
            for (int i = 0; i < t.len(); i++) v = v * 10 + 200'(t[i] - "0");
            s = s + v;
        end
        while (s >= 200'd10000000000) s = s / 10;
        return s[39:0];
    endfunction

    task automatic expect_a(input logic [39:0] r, input logic [15:0] c, input logic e);
        exp_t x;
        x = '{res: r, cnt: c, err: e};
        q_a.push_back(x);
    endtask

    task automatic expect_b(input logic [39:0] r, input logic [15:0] c, input logic e);
        exp_t x;
        x = '{res: r, cnt: c, err: e};
        q_b.push_back(x);
    endtask

    always @(negedge clk) begin
        if (done_a && !pd_a) begin
            if (q_a.size() == 0) check("a_unexpected_done", 64'(q_a.size()), 64'd1);
            else begin
                e_a = q_a.pop_front();
                check("a_result", 64'(res_a), 64'(e_a.res));
                check("a_count", 64'(cnt_a), 64'(e_a.cnt));
                check("a_error", 64'(err_a), 64'(e_a.err));
            end
        end
        pd_a = done_a;
        if (done_b && !pd_b) begin
            if (q_b.size() == 0) check("b_unexpected_done", 64'(q_b.size()), 64'd1);
            else begin
                e_b = q_b.pop_front();
                check("b_result", 64'(res_b), 64'(e_b.res));
                check("b_count", 64'(cnt_b), 64'(e_b.cnt));
                check("b_error", 64'(err_b), 64'(e_b.err));
            end
        end
        pd_b = done_b;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d, input bit dl, input bit nl);
        int t = 0;
        while (!rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) begin
            check("ready_timeout", 64'(rdy), 64'd1);
            return;
        end
        din = d; dvalid = 1'b1; dlast = dl; nlast = nl;
        @(negedge clk);
        dvalid = 1'b0; dlast = 1'b0; nlast = 1'b0;
    endtask

    task automatic send_num(input string s, input bit nl, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
            beat(4'(s[i] - "0"), i == s.len() - 1, nl && i == s.len() - 1);
        end
    endtask

    task automatic run_euler(input int n, input bit fin);
        for (int k = 0; k < n; k++) send_num(euler[k], fin && k == n - 1, 0);
    endtask

    task automatic wait_done(input bit b);
        int t = 0;
        while (!(b ? done_b : done_a) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(b ? "b_done" : "a_done", 64'(b ? done_b : done_a), 64'd1);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_result"}, 64'(res_a), 64'd0);
        check({tag, "_count"}, 64'(cnt_a), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_error"}, 64'(err_a), 64'd0);
        check({tag, "_ready"}, 64'(rdy_a), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dvalid = 1'b0; dlast = 1'b0; nlast = 1'b0; din = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_a("rst_a");
        check("rst_b_result", 64'(res_b), 64'd0);
        check("rst_b_done", 64'(done_b), 64'd0);
        check("rst_b_ready", 64'(rdy_b), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        expect_a(euler_lead(100), 16'd100, 1'b0);
        pulse_start();
        run_euler(100, 1'b1);
        wait_done(1'b0);

        expect_a(40'd0, 16'd0, 1'b1);
        pulse_start();
        beat(4'd1, 1'b0, 1'b0);
        beat(4'd2, 1'b0, 1'b0);
        beat(4'd12, 1'b0, 1'b0);
        check("bad_digit_ready", 64'(rdy_a), 64'd0);
        check("bad_digit_done", 64'(done_a), 64'd1);

        expect_a(40'd0, 16'd1, 1'b0);
        pulse_start();
        beat(4'd0, 1'b1, 1'b1);
        check("zero_add_done", 64'(done_a), 64'd0);
        @(negedge clk);
        check("zero_reduce_done", 64'(done_a), 64'd0);
        @(negedge clk);
        check("zero_final_done", 64'(done_a), 64'd1);

        pulse_start();
        run_euler(40, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_a("midrst_a");

        expect_a(euler_lead(100), 16'd100, 1'b0);
        pulse_start();
        run_euler(100, 1'b1);
        wait_done(1'b0);

        sel = 1'b1;
        expect_b(40'd10, 16'd2, 1'b0);
        pulse_start();
        send_num("99", 1'b0, 3);
        send_num("1", 1'b1, 3);
        wait_done(1'b1);

        expect_b(40'd7, 16'd1, 1'b0);
        pulse_start();
        send_num("7", 1'b1, 0);
        wait_done(1'b1);

        expect_b(40'd0, 16'd0, 1'b1);
        pulse_start();
        send_num("12345", 1'b1, 0);
        check("long_err_done", 64'(done_b), 64'd1);
        check("long_err_ready", 64'(rdy_b), 64'd0);
        @(negedge clk);
        check("long_err_ready_hold", 64'(rdy_b), 64'd0);

        repeat (3) @(negedge clk);
        check("sb_a_drained", 64'(q_a.size()), 64'd0);
        check("sb_b_drained", 64'(q_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
